// File: rtl/nmi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nmi_arbiter_pkg
// Purpose  : Shared types and constants for the /NMI arbiter slice.
//            nmi_state_t : arbiter FSM state encoding
//            NMI_VECTOR  : Z80 NMI restart address fetched under M1
// Revision : 1.0 - initial release
// ============================================================================
package nmi_arbiter_pkg;

  typedef enum logic [1:0] {
    NMI_IDLE     = 2'd0,
    NMI_WAIT_INT = 2'd1,
    NMI_ASSERT   = 2'd2,
    NMI_HOLD     = 2'd3
  } nmi_state_t;

  localparam logic [15:0] NMI_VECTOR = 16'h0066;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronises one asynchronous button level, accepts it once it
//            has been stable for DEBOUNCE_CYCLES clocks, and emits a single
//            clock pulse on each accepted 0->1 transition.
// Ports    : clk28 - system clock
//            rst_n - synchronous active-low reset
//            btn   - raw asynchronous button level, active-high
//            rise  - one-cycle pulse when the debounced level rises
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 280000
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_prev;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= 1'b0;
      // Any change of the synchronised level restarts the stability window;
      // the counter then parks at its maximum until the next change.
      if (r_sync != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        if (r_sync != r_level) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/nmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nmi_arbiter
// Purpose  : Shares the Z80 /NMI line between NREQ requesters. Each button is
//            debounced into a pending request; the lowest pending index is
//            served by asserting /NMI on the next /INT falling edge and
//            pulsing a one-hot grant when the CPU fetches the NMI vector.
// Ports    : clk28, rst_n     - clock, synchronous active-low reset
//            btn[NREQ]        - raw button levels (asynchronous)
//            req_en[NREQ]     - source enable; low masks and clears the source
//            busy[NREQ]       - source in its handler; masks new requests
//            n_int, n_int_next- current and next-cycle /INT level
//            bus_m1, bus_mreq, bus_a - CPU bus qualifiers and address
//            n_nmi            - /NMI to CPU, active-low
//            grant[NREQ]      - one-hot pulse on vector fetch
//            timeout          - pulse when a request is aborted
// Revision : 1.0 - initial release
// ============================================================================
module nmi_arbiter
  import nmi_arbiter_pkg::*;
#(
  parameter int NREQ            = 3,
  parameter int DEBOUNCE_CYCLES = 280000,
  parameter int TIMEOUT_FRAMES  = 4
) (
  input  logic            clk28,
  input  logic            rst_n,
  input  logic [NREQ-1:0] btn,
  input  logic [NREQ-1:0] req_en,
  input  logic [NREQ-1:0] busy,
  input  logic            n_int,
  input  logic            n_int_next,
  input  logic            bus_m1,
  input  logic            bus_mreq,
  input  logic [15:0]     bus_a,
  output logic            n_nmi,
  output logic [NREQ-1:0] grant,
  output logic            timeout
);

  localparam int SEL_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FCNT_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [FCNT_W-1:0] c_fcnt_last = FCNT_W'(TIMEOUT_FRAMES - 1);

  nmi_state_t        r_state, w_state_next;
  logic [SEL_W-1:0]  r_sel, w_sel_next, w_pick;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_next;
  logic [NREQ-1:0]   r_pending, w_pending_next;
  logic              r_n_nmi, w_n_nmi_next;
  logic [NREQ-1:0]   r_grant, w_grant_next;
  logic              r_timeout, w_timeout_next;
  logic [NREQ-1:0]   w_rise;
  logic              w_int_fall, w_vec_fetch;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk28 (clk28),
        .rst_n (rst_n),
        .btn   (btn[gi]),
        .rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_int_fall  = n_int & ~n_int_next;
  assign w_vec_fetch = bus_m1 & bus_mreq & (bus_a == NMI_VECTOR);

  // Priority encoder: lowest set index wins.
  always_comb begin
    w_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pick = SEL_W'(i);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_fcnt_next    = r_fcnt;
    w_n_nmi_next   = r_n_nmi;
    w_grant_next   = '0;
    w_timeout_next = 1'b0;
    case (r_state)
      NMI_IDLE: begin
        if (|r_pending) begin
          w_sel_next   = w_pick;
          w_state_next = NMI_WAIT_INT;
        end
      end
      NMI_WAIT_INT: begin
        if (!req_en[r_sel]) begin
          w_state_next = NMI_IDLE;
        end else if (w_int_fall) begin
          w_state_next = NMI_ASSERT;
          w_n_nmi_next = 1'b0;
          w_fcnt_next  = '0;
        end
      end
      NMI_ASSERT: begin
        // A vector fetch takes precedence over a coincident /INT edge.
        if (w_vec_fetch) begin
          for (int i = 0; i < NREQ; i++) w_grant_next[i] = (r_sel == SEL_W'(i));
          w_n_nmi_next = 1'b1;
          w_state_next = NMI_HOLD;
        end else if (w_int_fall) begin
          if (r_fcnt == c_fcnt_last) begin
            w_n_nmi_next   = 1'b1;
            w_timeout_next = 1'b1;
            w_state_next   = NMI_IDLE;
          end else begin
            w_fcnt_next = r_fcnt + FCNT_W'(1);
          end
        end
      end
      NMI_HOLD: begin
        // Frame count carries over from ASSERT so the whole service window
        // is bounded, not just the wait for the vector fetch.
        if (busy[r_sel]) begin
          w_state_next = NMI_IDLE;
        end else if (w_int_fall) begin
          if (r_fcnt == c_fcnt_last) begin
            w_timeout_next = 1'b1;
            w_state_next   = NMI_IDLE;
          end else begin
            w_fcnt_next = r_fcnt + FCNT_W'(1);
          end
        end
      end
      default: w_state_next = NMI_IDLE;
    endcase
  end

  // Clears use the next-cycle grant/timeout so the pending bit drops on the
  // same edge the pulse appears and IDLE never re-selects a served source.
  always_comb begin
    w_pending_next = r_pending;
    for (int i = 0; i < NREQ; i++) begin
      if (!req_en[i] || w_grant_next[i] || (w_timeout_next && r_sel == SEL_W'(i))) begin
        w_pending_next[i] = 1'b0;
      end else if (w_rise[i] && !busy[i] &&
                   !(r_state != NMI_IDLE && r_sel == SEL_W'(i))) begin
        w_pending_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_state   <= NMI_IDLE;
      r_sel     <= '0;
      r_fcnt    <= '0;
      r_pending <= '0;
      r_n_nmi   <= 1'b1;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_fcnt    <= w_fcnt_next;
      r_pending <= w_pending_next;
      r_n_nmi   <= w_n_nmi_next;
      r_grant   <= w_grant_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign n_nmi   = r_n_nmi;
  assign grant   = r_grant;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_nmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmi_arbiter
// Purpose  : Self-checking bench for nmi_arbiter (NREQ=3, DEBOUNCE_CYCLES=8,
//            TIMEOUT_FRAMES=2). Grant/timeout pulses are matched against a
//            queue of expected events; other checks are inline per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmi_arbiter;
  import nmi_arbiter_pkg::*;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic [2:0]  btn, req_en, busy;
  logic        n_int, n_int_next, bus_m1, bus_mreq;
  logic [15:0] bus_a;
  logic        n_nmi, timeout;
  logic [2:0]  grant;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic       s;

  nmi_arbiter #(.NREQ(3), .DEBOUNCE_CYCLES(8), .TIMEOUT_FRAMES(2)) dut (
    .clk28(clk28), .rst_n(rst_n), .btn(btn), .req_en(req_en), .busy(busy),
    .n_int(n_int), .n_int_next(n_int_next), .bus_m1(bus_m1), .bus_mreq(bus_mreq),
    .bus_a(bus_a), .n_nmi(n_nmi), .grant(grant), .timeout(timeout)
  );

  always #5 clk28 = ~clk28;

  // Scoreboard: every grant/timeout pulse must match the oldest expected event.
  always @(negedge clk28) begin
    if (grant != 3'b000 || timeout) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got timeout=%0b grant=%b, required no event", timeout, grant);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({timeout, grant} !== mon_exp) begin
          bad++;
          $display("FAIL event: got timeout=%0b grant=%b, required timeout=%0b grant=%b",
                   timeout, grant, mon_exp[3], mon_exp[2:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic press(input int idx, input int n);
    btn[idx] = 1'b1;
    tick(n);
    btn[idx] = 1'b0;
  endtask

  // One /INT falling edge; nmi_seen is n_nmi one clock after the edge cycle.
  task automatic int_edge(output logic nmi_seen);
    n_int_next = 1'b0;
    tick(1);
    nmi_seen   = n_nmi;
    n_int      = 1'b0;
    n_int_next = 1'b1;
    tick(1);
    n_int      = 1'b1;
  endtask

  task automatic fetch();
    bus_m1 = 1'b1; bus_mreq = 1'b1; bus_a = 16'h0066;
    tick(1);
    bus_m1 = 1'b0; bus_mreq = 1'b0; bus_a = 16'h0000;
  endtask

  task automatic busy_pulse(input int idx);
    busy[idx] = 1'b1;
    tick(1);
    busy[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++; if (n_nmi !== 1'b1) begin bad++; $display("FAIL reset_n_nmi: got %b required 1", n_nmi); end
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b required 000", grant); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b required 0", timeout); end
    total++; if (dut.r_pending !== 3'b000) begin bad++; $display("FAIL reset_pending: got %b required 000", dut.r_pending); end
    total++; if (dut.r_state !== NMI_IDLE) begin bad++; $display("FAIL reset_state: got %0d required %0d", dut.r_state, NMI_IDLE); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    press(0, 20);
    tick(3);
    total++; if (dut.r_pending !== 3'b001) begin bad++; $display("FAIL single_pending: got %b required 001", dut.r_pending); end
    total++; if (n_nmi !== 1'b1) begin bad++; $display("FAIL single_pre_edge: got %b required 1", n_nmi); end
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL single_nmi_latency: got %b required 0", s); end
    tick(2);
    total++; if (n_nmi !== 1'b0) begin bad++; $display("FAIL single_nmi_hold: got %b required 0", n_nmi); end
    exp_q.push_back({1'b0, 3'b001});
    fetch();
    total++; if (grant !== 3'b001 || n_nmi !== 1'b1) begin bad++; $display("FAIL single_grant: got grant=%b n_nmi=%b required 001/1", grant, n_nmi); end
    tick(1);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL single_grant_width: got %b required 000", grant); end
    busy_pulse(0);
    tick(1);
    total++; if (dut.r_state !== NMI_IDLE) begin bad++; $display("FAIL single_idle: got %0d required %0d", dut.r_state, NMI_IDLE); end
    fetch();
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL stray_fetch: got %b required 000", grant); end
    tick(10);
  endtask

  task automatic test_glitch();
    repeat (3) begin
      press(0, 3);
      tick(3);
    end
    tick(15);
    total++; if (dut.r_pending !== 3'b000) begin bad++; $display("FAIL glitch_pending: got %b required 000", dut.r_pending); end
    int_edge(s);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL glitch_n_nmi: got %b required 1", s); end
  endtask

  task automatic test_simultaneous();
    btn[1] = 1'b1; btn[2] = 1'b1;
    tick(20);
    btn[1] = 1'b0; btn[2] = 1'b0;
    tick(3);
    total++; if (dut.r_pending !== 3'b110) begin bad++; $display("FAIL simul_pending: got %b required 110", dut.r_pending); end
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL simul_nmi1: got %b required 0", s); end
    exp_q.push_back({1'b0, 3'b010});
    fetch();
    total++; if (grant !== 3'b010) begin bad++; $display("FAIL simul_grant1: got %b required 010", grant); end
    busy_pulse(1);
    tick(2);
    total++; if (dut.r_state !== NMI_WAIT_INT || dut.r_pending !== 3'b100) begin bad++; $display("FAIL simul_second_pending: got state=%0d pending=%b required %0d/100", dut.r_state, dut.r_pending, NMI_WAIT_INT); end
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL simul_nmi2: got %b required 0", s); end
    exp_q.push_back({1'b0, 3'b100});
    fetch();
    total++; if (grant !== 3'b100) begin bad++; $display("FAIL simul_grant2: got %b required 100", grant); end
    busy_pulse(2);
    tick(2);
    total++; if (dut.r_state !== NMI_IDLE || dut.r_pending !== 3'b000) begin bad++; $display("FAIL simul_done: got state=%0d pending=%b required %0d/000", dut.r_state, dut.r_pending, NMI_IDLE); end
    tick(10);
  endtask

  task automatic test_timeout();
    press(0, 20);
    tick(3);
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL to_assert: got %b required 0", s); end
    tick(3);
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL to_first_frame: got %b required 0", s); end
    tick(3);
    exp_q.push_back({1'b1, 3'b000});
    int_edge(s);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL to_release: got %b required 1", s); end
    total++; if (dut.r_state !== NMI_IDLE || dut.r_pending !== 3'b000 || timeout !== 1'b0) begin bad++; $display("FAIL to_after: got state=%0d pending=%b timeout=%b required %0d/000/0", dut.r_state, dut.r_pending, timeout, NMI_IDLE); end
    tick(10);
  endtask

  task automatic test_fetch_int_same();
    press(0, 20);
    tick(3);
    int_edge(s);
    tick(2);
    int_edge(s);
    tick(2);
    exp_q.push_back({1'b0, 3'b001});
    n_int_next = 1'b0;
    bus_m1 = 1'b1; bus_mreq = 1'b1; bus_a = 16'h0066;
    tick(1);
    bus_m1 = 1'b0; bus_mreq = 1'b0; bus_a = 16'h0000;
    total++; if (grant !== 3'b001 || timeout !== 1'b0 || n_nmi !== 1'b1) begin bad++; $display("FAIL same_cycle: got grant=%b timeout=%b n_nmi=%b required 001/0/1", grant, timeout, n_nmi); end
    n_int = 1'b0; n_int_next = 1'b1;
    tick(1);
    n_int = 1'b1;
    total++; if (dut.r_state !== NMI_HOLD) begin bad++; $display("FAIL same_cycle_hold: got %0d required %0d", dut.r_state, NMI_HOLD); end
    busy_pulse(0);
    tick(10);
  endtask

  task automatic test_masking();
    busy[0] = 1'b1;
    press(0, 20);
    tick(3);
    total++; if (dut.r_pending !== 3'b000 || dut.r_state !== NMI_IDLE) begin bad++; $display("FAIL busy_mask: got pending=%b state=%0d required 000/%0d", dut.r_pending, dut.r_state, NMI_IDLE); end
    busy[0] = 1'b0;
    tick(10);
    press(1, 20);
    tick(3);
    total++; if (dut.r_state !== NMI_WAIT_INT) begin bad++; $display("FAIL en_wait: got %0d required %0d", dut.r_state, NMI_WAIT_INT); end
    req_en[1] = 1'b0;
    tick(1);
    total++; if (dut.r_state !== NMI_IDLE || dut.r_pending !== 3'b000) begin bad++; $display("FAIL en_drop: got state=%0d pending=%b required %0d/000", dut.r_state, dut.r_pending, NMI_IDLE); end
    int_edge(s);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL en_drop_nmi: got %b required 1", s); end
    req_en[1] = 1'b1;
    tick(10);
  endtask

  task automatic test_reset_mid();
    press(0, 20);
    tick(3);
    int_edge(s);
    total++; if (dut.r_state !== NMI_ASSERT) begin bad++; $display("FAIL mid_assert: got %0d required %0d", dut.r_state, NMI_ASSERT); end
    rst_n = 1'b0;
    tick(1);
    total++; if (n_nmi !== 1'b1 || grant !== 3'b000 || dut.r_pending !== 3'b000 || dut.r_state !== NMI_IDLE) begin bad++; $display("FAIL mid_reset: got n_nmi=%b grant=%b pending=%b state=%0d required 1/000/000/%0d", n_nmi, grant, dut.r_pending, dut.r_state, NMI_IDLE); end
    rst_n = 1'b1;
    tick(15);
    press(0, 20);
    tick(3);
    int_edge(s);
    total++; if (s !== 1'b0) begin bad++; $display("FAIL post_reset_nmi: got %b required 0", s); end
    exp_q.push_back({1'b0, 3'b001});
    fetch();
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL post_reset_grant: got %b required 001", grant); end
    busy_pulse(0);
    tick(2);
    total++; if (dut.r_state !== NMI_IDLE) begin bad++; $display("FAIL post_reset_idle: got %0d required %0d", dut.r_state, NMI_IDLE); end
  endtask

  initial begin
    rst_n = 1'b0; btn = 3'b000; req_en = 3'b111; busy = 3'b000;
    n_int = 1'b1; n_int_next = 1'b1; bus_m1 = 1'b0; bus_mreq = 1'b0; bus_a = 16'h0000;
    test_reset();
    test_single();
    test_glitch();
    test_simultaneous();
    test_timeout();
    test_fetch_int_same();
    test_masking();
    test_reset_mid();
    tick(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding events, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
